sound_scheduler: RTL and testbench

//  Sequences and shares the tone generator between two requesters. Each request is one

---
 rtl/sound_scheduler.sv | 133 +++++++++++++
 tb/tb_sound_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_scheduler.sv
// Sound scheduler: shares one tone generator between a priority requester (A)
// and a playback requester (B), timing each note and a silent gap in ms.
module sound_scheduler #(
    parameter int DUR_W  = 10,
    parameter int GAP_MS = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ticks_per_milli,
    input  logic             a_req,
    input  logic [9:0]       a_freq,
    input  logic [DUR_W-1:0] a_dur,
    output logic             a_ack,
    input  logic             b_req,
    input  logic [9:0]       b_freq,
    input  logic [DUR_W-1:0] b_dur,
    output logic             b_ack,
    input  logic             abort,
    output logic [9:0]       freq,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [DUR_W-1:0] GAP_LEN = DUR_W'(GAP_MS);
    localparam bit               HAS_GAP = (GAP_MS > 0);

    state_t           state;
    logic [5:0]       tick_cnt;
    logic [5:0]       tick_max;
    logic [DUR_W-1:0] ms_cnt;
    logic [DUR_W-1:0] ms_next;
    logic [DUR_W-1:0] dur_q;
    logic             ms_strobe;
    logic             grant_a;
    logic             grant_b;
    logic [9:0]       g_freq;
    logic [DUR_W-1:0] g_dur;

    // >= rather than == so a shrinking tick count ends the ms at once
    always_comb begin
        tick_max  = (ticks_per_milli == 6'd0) ? 6'd0 : ticks_per_milli - 6'd1;
        ms_strobe = (state != IDLE) && (tick_cnt >= tick_max);
        ms_next   = ms_cnt + DUR_W'(1);
        grant_a   = a_req;
        grant_b   = b_req && !a_req;
        g_freq    = grant_a ? a_freq : b_freq;
        g_dur     = grant_a ? a_dur : b_dur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            freq     <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            dur_q    <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                freq     <= '0;
                busy     <= 1'b0;
                tick_cnt <= '0;
                ms_cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (a_req || b_req) begin
                            a_ack    <= grant_a;
                            b_ack    <= grant_b;
                            dur_q    <= g_dur;
                            tick_cnt <= '0;
                            ms_cnt   <= '0;
                            if (g_dur != '0) begin
                                freq  <= g_freq;
                                state <= PLAY;
                                busy  <= 1'b1;
                            end else if (HAS_GAP) begin
                                state <= GAP;
                                busy  <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    PLAY: begin
                        if (ms_strobe) begin
                            tick_cnt <= '0;
                            if (ms_next == dur_q) begin
                                freq   <= '0;
                                ms_cnt <= '0;
                                if (HAS_GAP) begin
                                    state <= GAP;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                ms_cnt <= ms_next;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                    GAP: begin
                        if (ms_strobe) begin
                            tick_cnt <= '0;
                            if (ms_next == GAP_LEN) begin
                                ms_cnt <= '0;
                                state  <= IDLE;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                            end else begin
                                ms_cnt <= ms_next;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: timestamp-based note model checked every cycle,
// plus directed scenarios with hand-computed cycle positions.
module tb_sound_scheduler;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] ticks_per_milli = 6'd4;
    logic       a_req = 1'b0, b_req = 1'b0, abort = 1'b0;
    logic [9:0] a_freq = '0, b_freq = '0, a_dur = '0, b_dur = '0;
    logic       a_ack, b_ack, busy, done;
    logic [9:0] freq;

    sound_scheduler #(.DUR_W(10), .GAP_MS(GAP)) dut (
        .clk(clk), .rst(rst), .ticks_per_milli(ticks_per_milli),
        .a_req(a_req), .a_freq(a_freq), .a_dur(a_dur), .a_ack(a_ack),
        .b_req(b_req), .b_freq(b_freq), .b_dur(b_dur), .b_ack(b_ack),
        .abort(abort), .freq(freq), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit model_on = 1'b1;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Model: a grant at edge g books the tone for [g, g+P) and the whole
    // note+gap for [g, g+P+G); done lands on edge g+P+G.
    int edge_n = 0;
    bit m_act = 0;
    int m_pend, m_end, m_f;
    int e_freq, e_busy, e_done, e_aack, e_back;

    task automatic model_step();
        int p, d;
        edge_n++;
        e_aack = 0;
        e_back = 0;
        e_done = 0;
        if (rst || abort) begin
            m_act = 0;
            e_freq = 0;
            e_busy = 0;
        end else if (m_act && edge_n < m_end) begin
            e_busy = 1;
            e_freq = (edge_n < m_pend) ? m_f : 0;
        end else if (m_act) begin
            m_act = 0;
            e_done = 1;
            e_busy = 0;
            e_freq = 0;
        end else if (a_req || b_req) begin
            p = (ticks_per_milli == 0) ? 1 : int'(ticks_per_milli);
            e_aack = a_req ? 1 : 0;
            e_back = a_req ? 0 : 1;
            m_f = a_req ? int'(a_freq) : int'(b_freq);
            d = a_req ? int'(a_dur) : int'(b_dur);
            m_pend = edge_n + d * p;
            m_end = m_pend + GAP * p;
            e_freq = (d > 0) ? m_f : 0;
            if (m_end == edge_n) begin
                e_done = 1;
                e_busy = 0;
            end else begin
                m_act = 1;
                e_busy = 1;
            end
        end else begin
            e_freq = 0;
            e_busy = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (model_on) begin
            chk("m_freq", int'(freq), e_freq);
            chk("m_busy", int'(busy), e_busy);
            chk("m_done", int'(done), e_done);
            chk("m_a_ack", int'(a_ack), e_aack);
            chk("m_b_ack", int'(b_ack), e_back);
        end
    end

    // Per-cycle log for directed scenarios; requesters drop req on ack.
    int lf[64];
    bit lbz[64], ld[64], la[64], lb[64];
    int nlog = 0;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            lf[i] = int'(freq);
            lbz[i] = busy;
            ld[i] = done;
            la[i] = a_ack;
            lb[i] = b_ack;
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
        end
        nlog = n;
    endtask

    function automatic bit sel(input int kind, input int i);
        case (kind)
            0: return ld[i];
            1: return la[i];
            2: return lb[i];
            default: return lbz[i];
        endcase
    endfunction

    function automatic int first(input int kind);
        for (int i = 0; i < nlog; i++)
            if (sel(kind, i)) return i;
        return -1;
    endfunction

    function automatic int count_k(input int kind);
        int c = 0;
        for (int i = 0; i < nlog; i++)
            if (sel(kind, i)) c++;
        return c;
    endfunction

    // v < 0 counts any nonzero tone
    function automatic int count_f(input int v);
        int c = 0;
        for (int i = 0; i < nlog; i++)
            if ((v < 0) ? (lf[i] != 0) : (lf[i] == v)) c++;
        return c;
    endfunction

    function automatic int count_gap();
        int c = 0;
        for (int i = 0; i < nlog; i++)
            if (lbz[i] && lf[i] == 0) c++;
        return c;
    endfunction

    task automatic set_a(input int f, input int d);
        a_req = 1'b1;
        a_freq = 10'(f);
        a_dur = 10'(d);
    endtask

    task automatic set_b(input int f, input int d);
        b_req = 1'b1;
        b_freq = 10'(f);
        b_dur = 10'(d);
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 400);
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int d, c1;
        repeat (3) @(negedge clk);
        chk("reset_out", int'({freq, busy, done, a_ack, b_ack}), 0);
        rst = 1'b0;
        @(negedge clk);

        // B note 440 Hz, 3 ms at 4 ticks/ms
        set_b(440, 3);
        run(30);
        chk("t1_b_acks", count_k(2), 1);
        chk("t1_tone_cycles", count_f(440), 12);
        chk("t1_gap_cycles", count_gap(), 8);
        d = first(0);
        chk("t1_done_idx", d, 20);
        chk("t1_busy_at_done", (d > 0) ? int'(lbz[d]) : 1, 0);

        // A and B together, A wins
        ticks_per_milli = 6'd1;
        set_a(100, 2);
        set_b(200, 1);
        run(12);
        chk("t2_a_ack_idx", first(1), 0);
        chk("t2_done_idx", first(0), 4);
        chk("t2_b_ack_idx", first(2), 5);
        chk("t2_b_tone", lf[5], 200);

        // A arrives mid-note of B: no preemption
        set_b(300, 5);
        run(2);
        set_a(500, 1);
        run(16);
        chk("t3_b_rest", count_f(300), 3);
        chk("t3_b_done_idx", first(0), 5);
        chk("t3_a_ack_idx", first(1), 6);
        chk("t3_a_tone", lf[6], 500);

        // zero-duration note
        ticks_per_milli = 6'd3;
        set_a(300, 0);
        run(12);
        chk("t4_ack_idx", first(1), 0);
        chk("t4_tone", count_f(-1), 0);
        chk("t4_done_idx", first(0), 6);

        // abort during ms 1, B pending
        ticks_per_milli = 6'd2;
        set_a(123, 4);
        run(3);
        abort = 1'b1;
        set_b(77, 1);
        @(negedge clk);
        chk("t5_abort_out", int'({freq, busy, done, b_ack}), 0);
        abort = 1'b0;
        run(10);
        chk("t5_b_ack_idx", first(2), 0);
        chk("t5_b_tone", lf[0], 77);
        chk("t5_done_cnt", count_k(0), 1);
        chk("t5_done_idx", first(0), 6);

        // tpm=0 acts as 1
        ticks_per_milli = 6'd0;
        set_a(60, 2);
        run(8);
        chk("t6_tpm0_tone", count_f(60), 2);
        chk("t6_tpm0_done", first(0), 4);

        // tpm 8 -> 2 when tick_cnt is 5 ends that ms the next cycle
        model_on = 1'b0;
        ticks_per_milli = 6'd8;
        set_a(50, 1);
        run(6);
        ticks_per_milli = 6'd2;
        c1 = count_f(50);
        run(10);
        chk("t6_shrink_tone", c1 + count_f(50), 6);
        chk("t6_shrink_done", first(0), 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_on = 1'b1;

        // reset mid-note, request held through reset is re-granted
        ticks_per_milli = 6'd1;
        set_a(9, 5);
        run(2);
        rst = 1'b1;
        set_a(11, 1);
        @(negedge clk);
        chk("t7_rst_out", int'({freq, busy}), 0);
        rst = 1'b0;
        run(3);
        chk("t7_regrant_idx", first(1), 0);
        chk("t7_regrant_tone", lf[0], 11);
        run(4);

        // randomized traffic checked by the model
        for (int seg = 0; seg < 6; seg++) begin
            ticks_per_milli = 6'($urandom_range(0, 5));
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (a_ack) a_req = 1'b0;
                else if (!a_req && $urandom_range(0, 7) == 0)
                    set_a($urandom_range(0, 1023), $urandom_range(0, 6));
                if (b_ack) b_req = 1'b0;
                else if (!b_req && $urandom_range(0, 5) == 0)
                    set_b($urandom_range(0, 1023), $urandom_range(0, 6));
                abort = ($urandom_range(0, 59) == 0);
            end
            a_req = 1'b0;
            b_req = 1'b0;
            abort = 1'b0;
            wait_idle();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
